fib_stack: RTL

- Frame stack (LIFO) for the recursive Fibonacci engine. It stores one call frame per push: a data word plus a 2-bit return code.
- Sits directly downstream of the Fibonacci controller. It consumes the controller's push/pop/tos strobes and the datapath's selected frame, and returns the popped frame, the return code (c_code) and stack_empty.

---
 rtl/fib_stack.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fib_stack.sv
// Frame stack (LIFO) for the recursive Fibonacci engine: {c_code, data} frames.
// Define FIB_STACK_HWM_EN to add the hwm (high-water mark) output.
module fib_stack #(
  parameter int DW    = 16,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [DW-1:0]            d_in,
  input  logic [1:0]               c_in,
  output logic [DW-1:0]            d_out,
  output logic [1:0]               c_code,
  output logic                     stack_empty,
  output logic                     stack_full,
  output logic [$clog2(DEPTH):0]   count,
`ifdef FIB_STACK_HWM_EN
  output logic [$clog2(DEPTH):0]   hwm,
`endif
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);

  logic [DW+1:0] r_mem [DEPTH];
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic [1:0]    r_code;
  logic          r_ovf;
  logic          r_unf;

  logic          w_empty;
  logic          w_full;
  logic [AW:0]   w_cm1;
  logic [AW-1:0] w_top;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic          w_rd;
  logic          w_set_ovf;
  logic          w_set_unf;
  logic [AW:0]   w_cnt_nx;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_cm1   = r_count - (AW+1)'(1);
  assign w_top   = w_cm1[AW-1:0];

  // A same-cycle push+pop replaces the top in place, so it is legal when full.
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_count[AW-1:0];
    w_rd      = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    w_cnt_nx  = r_count;
    if (!clr) begin
      if (push && pop) begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_rd    = 1'b1;
          w_waddr = w_top;
        end else begin
          w_waddr   = '0;
          w_cnt_nx  = (AW+1)'(1);
          w_set_unf = 1'b1;
        end
      end else if (push) begin
        if (tos) begin
          w_rd      = !w_empty;
          w_set_unf = w_empty;
        end
        if (!w_full) begin
          w_we     = 1'b1;
          w_cnt_nx = r_count + (AW+1)'(1);
        end else begin
          w_set_ovf = 1'b1;
        end
      end else if (pop) begin
        if (!w_empty) begin
          w_rd     = 1'b1;
          w_cnt_nx = w_cm1;
        end else begin
          w_set_unf = 1'b1;
        end
      end else if (tos) begin
        w_rd      = !w_empty;
        w_set_unf = w_empty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= {c_in, d_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_dout  <= '0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nx;
      if (w_rd) {r_code, r_dout} <= r_mem[w_top];
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

`ifdef FIB_STACK_HWM_EN
  logic [AW:0] r_hwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (clr) begin
      r_hwm <= '0;
    end else if (w_cnt_nx > r_hwm) begin
      r_hwm <= w_cnt_nx;
    end
  end

  assign hwm = r_hwm;
`endif

  assign d_out       = r_dout;
  assign c_code      = r_code;
  assign count       = r_count;
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;

endmodule
